// File: rtl/button_debouncer_if.sv
// rtl/button_debouncer_if.sv - button input and conditioned outputs of the debouncer
interface button_debouncer_if;
  logic button_n;
  logic reset_s2_n;
  logic button_pressed;
  logic button_state;

  modport master (
    output button_n,
    input  reset_s2_n,
    input  button_pressed,
    input  button_state
  );

  modport slave (
    input  button_n,
    output reset_s2_n,
    output button_pressed,
    output button_state
  );
endinterface

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - reset/button synchronizer, debounce FSM and one-cycle press pulse
// Optional auto-repeat pulses while held: define BUTTON_DEBOUNCER_AUTOREPEAT_EN
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES      = 1_000_000,
  parameter int REPEAT_DELAY_CYCLES  = 25_000_000,
  parameter int REPEAT_PERIOD_CYCLES = 5_000_000
) (
  input  logic              clock,
  input  logic              reset_n,
  button_debouncer_if.slave btn
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rst_s1_n;
  logic             rst_s2_n;
  logic             btn_s1;
  logic             btn_s2;
  logic             pressed_q;
  logic             state_q;

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int RPT_W = $clog2(REP_MAX + 1);

  logic [RPT_W-1:0] rep_cnt;
  logic             rep_first;
  logic [RPT_W-1:0] rep_target;

  // First repeat waits the long delay, later ones the shorter period.
  assign rep_target = rep_first ? RPT_W'(REPEAT_DELAY_CYCLES - 1)
                                : RPT_W'(REPEAT_PERIOD_CYCLES - 1);
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY_CYCLES + REPEAT_PERIOD_CYCLES;
`endif

  // Reset asserts asynchronously, releases two edges after reset_n rises.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_s1_n <= 1'b0;
      rst_s2_n <= 1'b0;
    end else begin
      rst_s1_n <= 1'b1;
      rst_s2_n <= rst_s1_n;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1    <= 1'b1;
      btn_s2    <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      pressed_q <= 1'b0;
      state_q   <= 1'b0;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
      rep_cnt   <= '0;
      rep_first <= 1'b1;
`endif
    end else if (!rst_s2_n) begin
      btn_s1    <= 1'b1;
      btn_s2    <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      pressed_q <= 1'b0;
      state_q   <= 1'b0;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
      rep_cnt   <= '0;
      rep_first <= 1'b1;
`endif
    end else begin
      btn_s1    <= btn.button_n;
      btn_s2    <= btn_s1;
      pressed_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!btn_s2) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state     <= PRESSED;
              state_q   <= 1'b1;
              pressed_q <= 1'b1;
              cnt       <= '0;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
              rep_cnt   <= '0;
              rep_first <= 1'b1;
`endif
            end else begin
              state <= PRESS_WAIT;
              cnt   <= CNT_ONE;
            end
          end
        end
        PRESS_WAIT: begin
          if (btn_s2) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= PRESSED;
            state_q   <= 1'b1;
            pressed_q <= 1'b1;
            cnt       <= '0;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
            rep_cnt   <= '0;
            rep_first <= 1'b1;
`endif
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (btn_s2) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state   <= IDLE;
              state_q <= 1'b0;
              cnt     <= '0;
            end else begin
              state <= RELEASE_WAIT;
              cnt   <= CNT_ONE;
            end
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
            rep_cnt <= '0;
          end else if (rep_cnt == rep_target) begin
            pressed_q <= 1'b1;
            rep_cnt   <= '0;
            rep_first <= 1'b0;
          end else begin
            rep_cnt <= rep_cnt + RPT_W'(1);
`endif
          end
        end
        RELEASE_WAIT: begin
          // A bounce back to low returns to PRESSED without a new pulse.
          if (!btn_s2) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= IDLE;
            state_q <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign btn.reset_s2_n     = rst_s2_n;
  assign btn.button_pressed = pressed_q;
  assign btn.button_state   = state_q;

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed bench for button_debouncer with a pulse-time scoreboard
module tb_button_debouncer;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 5;

  logic clock = 1'b0;
  logic reset_n;
  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];

  button_debouncer_if bif ();

  button_debouncer #(
    .DEBOUNCE_CYCLES      (DEB),
    .REPEAT_DELAY_CYCLES  (RD),
    .REPEAT_PERIOD_CYCLES (RP)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .btn     (bif)
  );

  always #5 clock = ~clock;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_edge(input int target);
    while (edge_cnt < target) @(negedge clock);
  endtask

  task automatic check_outs(input string tag, input int s2, input int pr, input int st);
    check({tag, "_reset_s2_n"}, int'(bif.reset_s2_n), s2);
    check({tag, "_pressed"}, int'(bif.button_pressed), pr);
    check({tag, "_state"}, int'(bif.button_state), st);
  endtask

  // Drive a press now; expected pulse edges follow from the 3-edge input delay plus debounce.
  task automatic press_hold(input int hold);
    int n;
    n = edge_cnt;
    bif.button_n = 1'b0;
    exp_q.push_back(n + DEB + 2);
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    for (int t = n + DEB + 2 + RD; t <= n + hold + 2; t += RP) exp_q.push_back(t);
`endif
    wait_edge(n + DEB + 1);
    check("press_state_before", int'(bif.button_state), 0);
    wait_edge(n + DEB + 2);
    check("press_state_after", int'(bif.button_state), 1);
    wait_edge(n + hold);
    bif.button_n = 1'b1;
  endtask

  task automatic release_check(input int m);
    wait_edge(m + DEB + 1);
    check("release_state_before", int'(bif.button_state), 1);
    wait_edge(m + DEB + 2);
    check("release_state_after", int'(bif.button_state), 0);
  endtask

  // Scoreboard: every observed pulse must match the next expected edge.
  always @(negedge clock) begin
    if (bif.button_pressed === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_pulse observed_edge=%0d expected=none", edge_cnt);
      end else begin
        int e;
        e = exp_q.pop_front();
        assert (edge_cnt === e) else begin
          errors++;
          $error("FAIL pulse_edge observed=%0d expected=%0d", edge_cnt, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int r;
    int m;

    // 1. reset synchronizer
    reset_n = 1'b0;
    bif.button_n = 1'b1;
    #1;
    check_outs("reset_imm", 0, 0, 0);
    repeat (3) begin
      @(negedge clock);
      check_outs("reset_hold", 0, 0, 0);
    end
    reset_n = 1'b1;
    r = edge_cnt;
    wait_edge(r + 1);
    check("reset_s2_edge1", int'(bif.reset_s2_n), 0);
    wait_edge(r + 2);
    check("reset_s2_edge2", int'(bif.reset_s2_n), 1);
    repeat (3) @(negedge clock);
    check_outs("idle", 1, 0, 0);

    // 2. clean press held 20 cycles, then clean release
    press_hold(20);
    release_check(edge_cnt);
    repeat (4) @(negedge clock);

    // 3. bounce rejection: low 3, high 1, low 2, high 10
    n = edge_cnt;
    bif.button_n = 1'b0;
    wait_edge(n + 3); bif.button_n = 1'b1;
    wait_edge(n + 4); bif.button_n = 1'b0;
    wait_edge(n + 6); bif.button_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wait_edge(n + i);
      check("bounce_state", int'(bif.button_state), 0);
    end

    // 4. release bounce: high 2, low 1, high 10
    press_hold(8);
    m = edge_cnt;
    wait_edge(m + 2); bif.button_n = 1'b0;
    wait_edge(m + 3); bif.button_n = 1'b1;
    for (int i = 1; i <= DEB + 4; i++) begin
      wait_edge(m + i);
      check("glitch_state_high", int'(bif.button_state), 1);
    end
    wait_edge(m + DEB + 5);
    check("glitch_state_fall", int'(bif.button_state), 0);
    repeat (4) @(negedge clock);

    // 5. reset while in PRESS_WAIT with cnt=2, button kept low
    n = edge_cnt;
    bif.button_n = 1'b0;
    wait_edge(n + 4);
    reset_n = 1'b0;
    #1;
    check_outs("midreset_imm", 0, 0, 0);
    repeat (3) begin
      @(negedge clock);
      check_outs("midreset_hold", 0, 0, 0);
    end
    reset_n = 1'b1;
    r = edge_cnt;
    exp_q.push_back(r + 2 + DEB + 2);
    wait_edge(r + 2);
    check("midreset_s2", int'(bif.reset_s2_n), 1);
    wait_edge(r + DEB + 3);
    check("midreset_state_before", int'(bif.button_state), 0);
    wait_edge(r + DEB + 4);
    check("midreset_state_after", int'(bif.button_state), 1);
    wait_edge(r + 10);
    bif.button_n = 1'b1;
    release_check(edge_cnt);
    repeat (4) @(negedge clock);

    // 6. long hold: pulse at +0, repeats only with auto-repeat enabled
    press_hold(37);
    release_check(edge_cnt);
    repeat (10) @(negedge clock);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
